alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/alu_core.sv | 50 +++++
 rtl/alu_issue.sv | 213 +++++++++++++++++++++
 tb/tb_alu_issue.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, opcode/funct encodings and the
// decoded-instruction entry carried through the issue pipeline.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_LUI  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_AND  = 5'd5,
    ALU_OR   = 5'd6,
    ALU_XOR  = 5'd7,
    ALU_NOR  = 5'd8,
    ALU_SLL  = 5'd9,
    ALU_SRL  = 5'd10,
    ALU_SRA  = 5'd11,
    ALU_SADD = 5'd12,
    ALU_SSUB = 5'd13
  } alu_code_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    alu_code_e        code;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [4:0]       dest;
    logic [XLEN-1:0]  pc;
    logic             ri;
  } dec_entry_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: computes the result for one ALU code and flags
// signed overflow for the trapping add/sub codes.
module alu_core
  import cpu_pkg::*;
(
  input  alu_code_e         code,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  output logic [XLEN-1:0]   result,
  output logic              overflow
);

  logic signed [XLEN-1:0] src1_s;
  logic signed [XLEN-1:0] src2_s;
  logic        [XLEN-1:0] sum;
  logic        [XLEN-1:0] diff;
  logic        [4:0]      sh;

  assign src1_s = src1;
  assign src2_s = src2;
  assign sum    = src1 + src2;
  assign diff   = src1 - src2;
  assign sh     = src1[4:0];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (code)
      ALU_ADD, ALU_SADD: result = sum;
      ALU_SUB, ALU_SSUB: result = diff;
      ALU_LUI:  result = {src2[15:0], 16'h0000};
      ALU_SLT:  result = {31'b0, src1_s < src2_s};
      ALU_SLTU: result = {31'b0, src1 < src2};
      ALU_AND:  result = src1 & src2;
      ALU_OR:   result = src1 | src2;
      ALU_XOR:  result = src1 ^ src2;
      ALU_NOR:  result = ~(src1 | src2);
      ALU_SLL:  result = src2 << sh;
      ALU_SRL:  result = src2 >> sh;
      ALU_SRA:  result = $unsigned(src2_s >>> sh);
      default:  result = '0;
    endcase
    // Overflow: result sign disagrees with src1 when it should not have moved.
    if (code == ALU_SADD)
      overflow = (src1[31] == src2[31]) && (sum[31] != src1[31]);
    else if (code == ALU_SSUB)
      overflow = (src1[31] != src2[31]) && (diff[31] != src1[31]);
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue pipeline: decode, operand select and ALU with valid/ready handshakes.
// Optional macro ALU_OVERFLOW_TRAP_EN enables overflow exceptions on add/sub/addi.
module alu_issue
  import cpu_pkg::*;
#(
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [5:0]       in_funct,
  input  logic [4:0]       in_shamt,
  input  logic [15:0]      in_imm,
  input  logic [XLEN-1:0]  in_rs_val,
  input  logic [XLEN-1:0]  in_rt_val,
  input  logic [4:0]       in_dest,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [4:0]       out_dest,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_wen,
  output logic             out_excep_ov,
  output logic             out_excep_ri,
  input  logic             flush
);

`ifdef ALU_OVERFLOW_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam alu_code_e ADD_TRAP = TRAP_EN ? ALU_SADD : ALU_ADD;
  localparam alu_code_e SUB_TRAP = TRAP_EN ? ALU_SSUB : ALU_SUB;

  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] imm_zext;
  dec_entry_t      dec_p0;
  dec_entry_t      ent_s;
  logic            vld_s;
  logic            accept;
  logic            adv_p2;

  assign imm_sext = {{16{in_imm[15]}}, in_imm};
  assign imm_zext = {16'h0000, in_imm};

  // Stage 0: decode the incoming instruction into ALU code and operands.
  always_comb begin
    dec_p0.code = ALU_ADD;
    dec_p0.src1 = in_rs_val;
    dec_p0.src2 = in_rt_val;
    dec_p0.dest = in_dest;
    dec_p0.pc   = in_pc;
    dec_p0.ri   = 1'b0;
    case (in_op)
      OP_SPECIAL: begin
        case (in_funct)
          FN_ADD:  dec_p0.code = ADD_TRAP;
          FN_ADDU: dec_p0.code = ALU_ADD;
          FN_SUB:  dec_p0.code = SUB_TRAP;
          FN_SUBU: dec_p0.code = ALU_SUB;
          FN_AND:  dec_p0.code = ALU_AND;
          FN_OR:   dec_p0.code = ALU_OR;
          FN_XOR:  dec_p0.code = ALU_XOR;
          FN_NOR:  dec_p0.code = ALU_NOR;
          FN_SLT:  dec_p0.code = ALU_SLT;
          FN_SLTU: dec_p0.code = ALU_SLTU;
          FN_SLL: begin
            dec_p0.code = ALU_SLL;
            dec_p0.src1 = {27'b0, in_shamt};
          end
          FN_SRL: begin
            dec_p0.code = ALU_SRL;
            dec_p0.src1 = {27'b0, in_shamt};
          end
          FN_SRA: begin
            dec_p0.code = ALU_SRA;
            dec_p0.src1 = {27'b0, in_shamt};
          end
          FN_SLLV: dec_p0.code = ALU_SLL;
          FN_SRLV: dec_p0.code = ALU_SRL;
          FN_SRAV: dec_p0.code = ALU_SRA;
          default: dec_p0.ri = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec_p0.code = ADD_TRAP;
        dec_p0.src2 = imm_sext;
      end
      OP_ADDIU: begin
        dec_p0.code = ALU_ADD;
        dec_p0.src2 = imm_sext;
      end
      OP_SLTI: begin
        dec_p0.code = ALU_SLT;
        dec_p0.src2 = imm_sext;
      end
      OP_SLTIU: begin
        dec_p0.code = ALU_SLTU;
        dec_p0.src2 = imm_sext;
      end
      OP_ANDI: begin
        dec_p0.code = ALU_AND;
        dec_p0.src2 = imm_zext;
      end
      OP_ORI: begin
        dec_p0.code = ALU_OR;
        dec_p0.src2 = imm_zext;
      end
      OP_XORI: begin
        dec_p0.code = ALU_XOR;
        dec_p0.src2 = imm_zext;
      end
      OP_LUI: begin
        dec_p0.code = ALU_LUI;
        dec_p0.src2 = imm_zext;
      end
      default: dec_p0.ri = 1'b1;
    endcase
  end

  logic            vld_p2;
  logic [XLEN-1:0] res_p2;
  logic [4:0]      dest_p2;
  logic [XLEN-1:0] pc_p2;
  logic            wen_p2;
  logic            ov_p2;
  logic            ri_p2;

  assign adv_p2 = !vld_p2 || out_ready;
  assign accept = in_valid && in_ready;

  // Stage 1: decoded entry register, or a direct path when the pipe is merged.
  if (PIPE_STAGES == 1) begin : g_merged
    assign in_ready = !flush && adv_p2;
    assign vld_s    = accept;
    assign ent_s    = dec_p0;
  end else begin : g_split
    logic       vld_p1;
    dec_entry_t ent_p1;

    assign in_ready = !flush && (!vld_p1 || adv_p2);

    always_ff @(posedge clk or posedge reset) begin
      if (reset)       vld_p1 <= 1'b0;
      else if (flush)  vld_p1 <= 1'b0;
      else if (accept) vld_p1 <= 1'b1;
      else if (adv_p2) vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (accept) ent_p1 <= dec_p0;
    end

    assign vld_s = vld_p1;
    assign ent_s = ent_p1;
  end

  logic [XLEN-1:0] alu_res;
  logic            alu_ov;
  logic            ov_s;
  logic            wen_s;
  logic [XLEN-1:0] res_s;

  alu_core u_alu (
    .code     (ent_s.code),
    .src1     (ent_s.src1),
    .src2     (ent_s.src2),
    .result   (alu_res),
    .overflow (alu_ov)
  );

  assign ov_s  = TRAP_EN && alu_ov && !ent_s.ri;
  assign wen_s = !ent_s.ri && !ov_s && (ent_s.dest != 5'd0);
  assign res_s = ent_s.ri ? '0 : alu_res;

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      res_p2  <= '0;
      dest_p2 <= '0;
      pc_p2   <= '0;
      wen_p2  <= 1'b0;
      ov_p2   <= 1'b0;
      ri_p2   <= 1'b0;
    end else begin
      if (flush)       vld_p2 <= 1'b0;
      else if (adv_p2) vld_p2 <= vld_s;
      if (!flush && adv_p2 && vld_s) begin
        res_p2  <= res_s;
        dest_p2 <= ent_s.dest;
        pc_p2   <= ent_s.pc;
        wen_p2  <= wen_s;
        ov_p2   <= ov_s;
        ri_p2   <= ent_s.ri;
      end
    end
  end

  assign out_valid    = vld_p2;
  assign out_result   = res_p2;
  assign out_dest     = dest_p2;
  assign out_pc       = pc_p2;
  assign out_wen      = wen_p2;
  assign out_excep_ov = ov_p2;
  assign out_excep_ri = ri_p2;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: queue-based reference model plus directed
// literal checks, then randomized traffic with stalls, flushes and a mid-run reset.
module tb_alu_issue;

  localparam int PIPE = 2;
`ifdef ALU_OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [31:0] in_rs_val = '0;
  logic [31:0] in_rt_val = '0;
  logic [4:0]  in_dest = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic [31:0] out_pc;
  logic        out_wen;
  logic        out_excep_ov;
  logic        out_excep_ri;
  logic        flush = 1'b0;

  alu_issue #(.PIPE_STAGES(PIPE)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct(in_funct), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_dest(in_dest), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .out_pc(out_pc),
    .out_wen(out_wen), .out_excep_ov(out_excep_ov), .out_excep_ri(out_excep_ri),
    .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic        wen;
    logic        ov;
    logic        ri;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [31:0] out_log[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          saw_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: what the instruction must produce, straight from the ISA rules.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] funct,
                                 input logic [4:0] shamt, input logic [15:0] imm,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] dest, input logic [31:0] pc);
    exp_t e;
    logic [31:0] se, ze, r;
    longint wide;
    bit trap_chk, ri;
    se = {{16{imm[15]}}, imm};
    ze = {16'h0000, imm};
    r = '0; ri = 1'b0; trap_chk = 1'b0; wide = 0;
    if (op == 6'h00) begin
      case (funct)
        6'h20: begin r = rs + rt; wide = longint'($signed(rs)) + longint'($signed(rt)); trap_chk = TRAP; end
        6'h21: r = rs + rt;
        6'h22: begin r = rs - rt; wide = longint'($signed(rs)) - longint'($signed(rt)); trap_chk = TRAP; end
        6'h23: r = rs - rt;
        6'h24: r = rs & rt;
        6'h25: r = rs | rt;
        6'h26: r = rs ^ rt;
        6'h27: r = ~(rs | rt);
        6'h2A: r = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
        6'h2B: r = (rs < rt) ? 32'd1 : 32'd0;
        6'h00: r = rt << shamt;
        6'h04: r = rt << rs[4:0];
        6'h02: r = rt >> shamt;
        6'h06: r = rt >> rs[4:0];
        6'h03: r = $signed(rt) >>> shamt;
        6'h07: r = $signed(rt) >>> rs[4:0];
        default: ri = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08: begin r = rs + se; wide = longint'($signed(rs)) + longint'($signed(se)); trap_chk = TRAP; end
        6'h09: r = rs + se;
        6'h0A: r = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0B: r = (rs < se) ? 32'd1 : 32'd0;
        6'h0C: r = rs & ze;
        6'h0D: r = rs | ze;
        6'h0E: r = rs ^ ze;
        6'h0F: r = {imm, 16'h0000};
        default: ri = 1'b1;
      endcase
    end
    e.ov = trap_chk && (wide != longint'($signed(r)));
    if (ri) r = '0;
    e.result = r;
    e.ri = ri;
    e.wen = !ri && !e.ov && (dest != 5'd0);
    e.dest = dest;
    e.pc = pc;
    e.t = 0;
    return e;
  endfunction

  // Compare process: every falling edge, check handshake and head-of-queue data.
  always @(negedge clk) begin
    bit   exp_rdy, exp_vld;
    exp_t e;
    if (reset) begin
      q.delete();
    end else begin
      cyc++;
      exp_rdy = !flush && ((q.size() < PIPE) || out_ready);
      exp_vld = 1'b0;
      if (q.size() > 0) exp_vld = (cyc - q[0].t) >= PIPE;
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_vld});
      if (exp_vld && out_valid) begin
        chk("out_result", out_result, q[0].result);
        chk("out_dest", {27'b0, out_dest}, {27'b0, q[0].dest});
        chk("out_pc", out_pc, q[0].pc);
        chk("out_flags(wen,ov,ri)", {29'b0, out_wen, out_excep_ov, out_excep_ri},
            {29'b0, q[0].wen, q[0].ov, q[0].ri});
      end
      if (in_valid && !in_ready && !flush) saw_stall = 1'b1;
      if (flush) begin
        q.delete();
      end else begin
        if (exp_vld && out_ready) begin
          out_log.push_back(out_result);
          void'(q.pop_front());
        end
        if (in_valid && exp_rdy) begin
          e = model(in_op, in_funct, in_shamt, in_imm, in_rs_val, in_rt_val, in_dest, in_pc);
          e.t = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [5:0] op, input logic [5:0] funct, input logic [4:0] shamt,
                      input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [4:0] dest, input logic [31:0] pc);
    bit ok;
    in_op = op; in_funct = funct; in_shamt = shamt; in_imm = imm;
    in_rs_val = rs; in_rt_val = rt; in_dest = dest; in_pc = pc;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL send_timeout: in_ready never asserted, expected 1");
  endtask

  // Wait for the next result, then check it against hand-computed literals.
  task automatic expect_out(input string name, input logic [31:0] res, input logic wen,
                            input logic ov, input logic ri, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid stayed 0, expected 1", name);
    end else begin
      chk({name, "_result"}, out_result, res);
      chk({name, "_flags(wen,ov,ri)"}, {29'b0, out_wen, out_excep_ov, out_excep_ri},
          {29'b0, wen, ov, ri});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < 50 && out_log.size() < n; i++) @(negedge clk);
    chk("drain_count", 32'(out_log.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [5:0] op_tab [12];
    logic [5:0] fn_tab [17];
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F};
    fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h3C};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_dest", {27'b0, out_dest}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_flags(wen,ov,ri)", {29'b0, out_wen, out_excep_ov, out_excep_ri}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed single instructions, out_ready high
    send(6'h00, 6'h20, 5'd0, 16'h0, 32'h7FFF_FFFF, 32'h1, 5'd3, 32'h100);
    in_valid = 1'b0;
    expect_out("add_ov", 32'h8000_0000, !TRAP, TRAP, 1'b0, lat);
    chk("add_ov_latency", 32'(lat), 32'(PIPE));
    chk("add_ov_dest", {27'b0, out_dest}, 32'd3);
    send(6'h00, 6'h03, 5'd4, 16'h0, 32'h0, 32'h8000_0000, 5'd5, 32'h104);
    in_valid = 1'b0;
    expect_out("sra", 32'hF800_0000, 1'b1, 1'b0, 1'b0, lat);
    send(6'h00, 6'h06, 5'd0, 16'h0, 32'd36, 32'h8000_0000, 5'd6, 32'h108);
    in_valid = 1'b0;
    expect_out("srlv", 32'h0800_0000, 1'b1, 1'b0, 1'b0, lat);
    send(6'h0A, 6'h00, 5'd0, 16'h0001, 32'hFFFF_FFFF, 32'h0, 5'd7, 32'h10C);
    in_valid = 1'b0;
    expect_out("slti", 32'd1, 1'b1, 1'b0, 1'b0, lat);
    send(6'h0B, 6'h00, 5'd0, 16'h0001, 32'hFFFF_FFFF, 32'h0, 5'd7, 32'h110);
    in_valid = 1'b0;
    expect_out("sltiu", 32'd0, 1'b1, 1'b0, 1'b0, lat);
    send(6'h0F, 6'h00, 5'd0, 16'h1234, 32'hDEAD_BEEF, 32'h0, 5'd8, 32'h114);
    in_valid = 1'b0;
    expect_out("lui", 32'h1234_0000, 1'b1, 1'b0, 1'b0, lat);
    send(6'h3F, 6'h00, 5'd0, 16'hFFFF, 32'h1, 32'h2, 5'd9, 32'h118);
    in_valid = 1'b0;
    expect_out("reserved", 32'd0, 1'b0, 1'b0, 1'b1, lat);
    send(6'h00, 6'h21, 5'd0, 16'h0, 32'd5, 32'd6, 5'd0, 32'h11C);
    in_valid = 1'b0;
    expect_out("addu_r0", 32'd11, 1'b0, 1'b0, 1'b0, lat);
    send(6'h00, 6'h22, 5'd0, 16'h0, 32'h8000_0000, 32'h1, 5'd10, 32'h120);
    in_valid = 1'b0;
    expect_out("sub_ov", 32'h7FFF_FFFF, !TRAP, TRAP, 1'b0, lat);
    send(6'h00, 6'h27, 5'd0, 16'h0, 32'h0, 32'h0F0F_0F0F, 5'd11, 32'h124);
    in_valid = 1'b0;
    expect_out("nor", 32'hF0F0_F0F0, 1'b1, 1'b0, 1'b0, lat);

    // Back-to-back with downstream stalled for three cycles
    out_log.delete();
    saw_stall = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        send(6'h00, 6'h21, 5'd0, 16'h0, 32'd1, 32'd2, 5'd1, 32'h200);
        send(6'h00, 6'h23, 5'd0, 16'h0, 32'd10, 32'd3, 5'd2, 32'h204);
        send(6'h00, 6'h24, 5'd0, 16'h0, 32'hF0, 32'hFF, 5'd3, 32'h208);
        send(6'h00, 6'h25, 5'd0, 16'h0, 32'h0F00, 32'h00F0, 5'd4, 32'h20C);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain(4);
    chk("stall_seen", {31'b0, saw_stall}, 32'd1);
    if (out_log.size() >= 4) begin
      chk("order0", out_log[0], 32'd3);
      chk("order1", out_log[1], 32'd7);
      chk("order2", out_log[2], 32'hF0);
      chk("order3", out_log[3], 32'h0FF0);
    end

    // Flush with two entries in flight and a third offered
    out_log.delete();
    out_ready = 1'b0;
    send(6'h00, 6'h21, 5'd0, 16'h0, 32'd1, 32'd1, 5'd1, 32'h300);
    send(6'h00, 6'h21, 5'd0, 16'h0, 32'd2, 32'd2, 5'd2, 32'h304);
    in_rs_val = 32'd3;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("flush_emitted", 32'(out_log.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of traffic
    out_ready = 1'b0;
    send(6'h00, 6'h21, 5'd0, 16'h0, 32'd4, 32'd4, 5'd1, 32'h400);
    send(6'h00, 6'h21, 5'd0, 16'h0, 32'd5, 32'd5, 5'd2, 32'h404);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (5) @(negedge clk);
    chk("midrst_emitted", 32'(out_log.size()), 32'd0);
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = op_tab[$urandom_range(0, 11)];
      in_funct  = fn_tab[$urandom_range(0, 16)];
      in_shamt  = 5'($urandom);
      in_imm    = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      in_rs_val = rval();
      in_rt_val = rval();
      in_dest   = 5'($urandom);
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 3);
      reset     = (i == 1500);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    flush = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("final_out_valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
